id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: in_valid in 1, in_ready out 1: decode-side handshake.
REQ-003 SHALL have ports: in_rs_data, in_rt_data, in_imm  in  32 each: register file reads and sign-extended immediate.
REQ-004 SHALL have ports: in_rs_addr, in_rt_addr, in_rd_addr  in  5 each; in_alu_op in 2; in_funct in 6; in_alu_src in 1 (1 = immediate as operand B).
REQ-005 SHALL have ports: flush  in  1  discard held instruction (branch taken).
REQ-006 SHALL have ports: fwd_mem_wen in 1, fwd_mem_addr in 5, fwd_mem_data in 32; fwd_wb_wen in 1, fwd_wb_addr in 5, fwd_wb_data in 32: forwarding sources.
REQ-007 SHALL have ports: out_valid out 1, out_ready in 1: ALU-side handshake; ALU_Control out 4; operand_A, operand_B out 32; out_rd_addr out 5.
REQ-008 SHALL use one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-009 SHALL hold one instruction in a single-entry register; latency in_valid-accept to out_valid = 1 cycle.
REQ-010 SHALL drive in_ready = !flush && (!out_valid || out_ready), combinationally.
REQ-011 SHALL capture inputs and set out_valid on an edge where in_valid && in_ready.
REQ-012 SHALL clear out_valid on an edge where out_valid && out_ready && no capture.
REQ-013 SHALL hold all outputs stable while out_valid && !out_ready (stall), except forwarded operand values per REQ-016.
REQ-014 SHALL, when flush is high at an edge, clear out_valid; flush wins over capture; simultaneous in_valid is dropped.
REQ-015 SHALL decode ALU_Control from held alu_op/funct: 00->0010; 01->0110; 11->0111; 10 with funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100, any other funct->0010.
REQ-016 SHALL select operands combinationally from the held entry every cycle: for each source address, MEM match (wen, addr equal, addr != 0) first, then WB match, else held register data.
REQ-017 SHALL never forward to address 0; register 0 operand is always the held value.
REQ-018 SHALL drive operand_B = held imm when held alu_src = 1, ignoring rt forwarding.
REQ-019 SHALL pass held rd_addr unchanged to out_rd_addr.

Reset
REQ-020 SHALL, on rst_n low, asynchronously clear out_valid and all held fields to 0 (ALU_Control = 0010, operands 0, out_rd_addr 0).
REQ-021 SHALL, on reset mid-stall, discard the held instruction; first capture after release occurs at the first edge with in_valid.

Configuration
REQ-022 SHALL implement forwarding (REQ-016..017) only when ID_EX_FWD_EN is defined.
REQ-023 SHALL, without ID_EX_FWD_EN, output held rs/rt data directly and leave fwd_* inputs unused; handshake and decode unchanged.

Structure
REQ-024 SHALL take ALU control codes (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100), alu_op encodings and funct codes from shared package cpu_pkg.
REQ-025 SHALL place the REQ-015 decoder in a combinational sub-module alu_ctrl_dec.

Verification
REQ-026 Accept: alu_op 10, funct 100010, rs_data 9, rt_data 4, alu_src 0, out_ready 1 -> next cycle out_valid 1, ALU_Control 0110, operand_A 9, operand_B 4.
REQ-027 Stall: out_ready 0 for 3 cycles with new in_valid -> in_ready 0, outputs unchanged, second instruction accepted the edge after out_ready rises.
REQ-028 Forward priority: held rs_addr 5, MEM wen addr 5 data 0x11, WB wen addr 5 data 0x22 -> operand_A 0x11; MEM wen dropped -> 0x22; rs_addr 0 with both matching addr 0 -> held data.
REQ-029 Flush with in_valid high, out_valid 1 -> in_ready 0, next cycle out_valid 0, new instruction not captured.
REQ-030 Reset asserted asynchronously mid-stall -> out_valid 0 immediately, ALU_Control 0010, operands 0; alu_src 1 imm 0xFFFFFFFC after release -> operand_B 0xFFFFFFFC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes, alu_op encodings, R-type funct codes,
// the ID/EX held-entry layout and the operand forwarding selection helper.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_SLT   = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    typedef struct packed {
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [1:0]        alu_op;
        logic [5:0]        funct;
        logic              alu_src;
        logic [XLEN-1:0]   rs_data;
        logic [XLEN-1:0]   rt_data;
        logic [XLEN-1:0]   imm;
    } id_ex_entry_t;

    // MEM result is younger than WB, so it takes priority; register 0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd_pick(
        input logic [REG_AW-1:0] src_addr,
        input logic [XLEN-1:0]   held_data,
        input logic              mem_wen,
        input logic [REG_AW-1:0] mem_addr,
        input logic [XLEN-1:0]   mem_data,
        input logic              wb_wen,
        input logic [REG_AW-1:0] wb_addr,
        input logic [XLEN-1:0]   wb_data
    );
        logic [XLEN-1:0] result;
        result = held_data;
        if (src_addr != '0) begin
            if (mem_wen && (mem_addr == src_addr)) begin
                result = mem_data;
            end else if (wb_wen && (wb_addr == src_addr)) begin
                result = wb_data;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: maps the held alu_op / funct pair onto
// the 4-bit ALU operation code.
module alu_ctrl_dec
    import cpu_pkg::*;
(
    input  logic [1:0] in_alu_op,
    input  logic [5:0] in_funct,
    output logic [3:0] out_alu_ctrl
);

    always_comb begin
        out_alu_ctrl = ALU_ADD;
        case (in_alu_op)
            ALUOP_ADD: out_alu_ctrl = ALU_ADD;
            ALUOP_SUB: out_alu_ctrl = ALU_SUB;
            ALUOP_SLT: out_alu_ctrl = ALU_SLT;
            ALUOP_FUNCT: begin
                case (in_funct)
                    FUNCT_ADD: out_alu_ctrl = ALU_ADD;
                    FUNCT_SUB: out_alu_ctrl = ALU_SUB;
                    FUNCT_AND: out_alu_ctrl = ALU_AND;
                    FUNCT_OR:  out_alu_ctrl = ALU_OR;
                    FUNCT_SLT: out_alu_ctrl = ALU_SLT;
                    FUNCT_NOR: out_alu_ctrl = ALU_NOR;
                    default:   out_alu_ctrl = ALU_ADD;
                endcase
            end
            default: out_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single-entry valid/ready stage with flush, ALU control
// decode and operand selection. Define ID_EX_FWD_EN to enable MEM/WB forwarding.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_rs_data,
    input  logic [XLEN-1:0]   in_rt_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [1:0]        in_alu_op,
    input  logic [5:0]        in_funct,
    input  logic              in_alu_src,

    input  logic              flush,

    input  logic              fwd_mem_wen,
    input  logic [REG_AW-1:0] fwd_mem_addr,
    input  logic [XLEN-1:0]   fwd_mem_data,
    input  logic              fwd_wb_wen,
    input  logic [REG_AW-1:0] fwd_wb_addr,
    input  logic [XLEN-1:0]   fwd_wb_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        ALU_Control,
    output logic [XLEN-1:0]   operand_A,
    output logic [XLEN-1:0]   operand_B,
    output logic [REG_AW-1:0] out_rd_addr
);

    logic         r_valid;
    id_ex_entry_t r_entry;
    id_ex_entry_t w_in_entry;
    logic         w_take;
    logic [XLEN-1:0] w_rs_val;
    logic [XLEN-1:0] w_rt_val;

    // A taken branch blocks acceptance so the wrong-path instruction is dropped.
    assign in_ready = !flush && (!r_valid || out_ready);
    assign w_take   = in_valid && in_ready;

    always_comb begin
        w_in_entry         = '0;
        w_in_entry.rs_addr = in_rs_addr;
        w_in_entry.rt_addr = in_rt_addr;
        w_in_entry.rd_addr = in_rd_addr;
        w_in_entry.alu_op  = in_alu_op;
        w_in_entry.funct   = in_funct;
        w_in_entry.alu_src = in_alu_src;
        w_in_entry.rs_data = in_rs_data;
        w_in_entry.rt_data = in_rt_data;
        w_in_entry.imm     = in_imm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_take) begin
                r_valid <= 1'b1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_take) begin
                r_entry <= w_in_entry;
            end
        end
    end

`ifdef ID_EX_FWD_EN
    assign w_rs_val = fwd_pick(r_entry.rs_addr, r_entry.rs_data,
                               fwd_mem_wen, fwd_mem_addr, fwd_mem_data,
                               fwd_wb_wen, fwd_wb_addr, fwd_wb_data);
    assign w_rt_val = fwd_pick(r_entry.rt_addr, r_entry.rt_data,
                               fwd_mem_wen, fwd_mem_addr, fwd_mem_data,
                               fwd_wb_wen, fwd_wb_addr, fwd_wb_data);
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_mem_wen, fwd_mem_addr, fwd_mem_data,
                            fwd_wb_wen, fwd_wb_addr, fwd_wb_data,
                            r_entry.rs_addr, r_entry.rt_addr};
    assign w_rs_val = r_entry.rs_data;
    assign w_rt_val = r_entry.rt_data;
`endif

    alu_ctrl_dec u_alu_ctrl_dec (
        .in_alu_op    (r_entry.alu_op),
        .in_funct     (r_entry.funct),
        .out_alu_ctrl (ALU_Control)
    );

    assign out_valid   = r_valid;
    assign operand_A   = w_rs_val;
    assign operand_B   = r_entry.alu_src ? r_entry.imm : w_rt_val;
    assign out_rd_addr = r_entry.rd_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_rs_data, in_rt_data, in_imm;
    logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
    logic [1:0]  in_alu_op;
    logic [5:0]  in_funct;
    logic        in_alu_src;
    logic        flush;
    logic        fwd_mem_wen, fwd_wb_wen;
    logic [4:0]  fwd_mem_addr, fwd_wb_addr;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        out_valid, out_ready;
    logic [3:0]  ALU_Control;
    logic [31:0] operand_A, operand_B;
    logic [4:0]  out_rd_addr;

    int n_checks = 0;
    int n_fail   = 0;

    // model of the held entry
    logic        m_valid;
    logic [4:0]  m_rs_addr, m_rt_addr, m_rd_addr;
    logic [1:0]  m_op;
    logic [5:0]  m_funct;
    logic        m_src;
    logic [31:0] m_rs_data, m_rt_data, m_imm;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
        .in_alu_op(in_alu_op), .in_funct(in_funct), .in_alu_src(in_alu_src),
        .flush(flush),
        .fwd_mem_wen(fwd_mem_wen), .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_wen(fwd_wb_wen), .fwd_wb_addr(fwd_wb_addr), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_Control(ALU_Control), .operand_A(operand_A), .operand_B(operand_B),
        .out_rd_addr(out_rd_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0111;
        if (f == 6'b100010) return 4'b0110;
        if (f == 6'b100100) return 4'b0000;
        if (f == 6'b100101) return 4'b0001;
        if (f == 6'b101010) return 4'b0111;
        if (f == 6'b100111) return 4'b1100;
        return 4'b0010;
    endfunction

    function automatic logic [31:0] opnd_ref(input logic [4:0] a, input logic [31:0] held);
`ifdef ID_EX_FWD_EN
        if (a != 0 && fwd_mem_wen && fwd_mem_addr == a) return fwd_mem_data;
        if (a != 0 && fwd_wb_wen && fwd_wb_addr == a) return fwd_wb_data;
`endif
        return held;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rs_addr = 0; m_rt_addr = 0; m_rd_addr = 0;
        m_op = 0; m_funct = 0; m_src = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".in_ready"}, in_ready, !flush && (!m_valid || out_ready));
        chk({ctx, ".out_valid"}, out_valid, m_valid);
        chk({ctx, ".alu_ctrl"}, ALU_Control, alu_ref(m_op, m_funct));
        chk({ctx, ".opA"}, operand_A, opnd_ref(m_rs_addr, m_rs_data));
        chk({ctx, ".opB"}, operand_B, m_src ? m_imm : opnd_ref(m_rt_addr, m_rt_data));
        chk({ctx, ".rd"}, out_rd_addr, m_rd_addr);
    endtask

    // check at the falling edge, then advance the model across the next rising edge
    task automatic cycle(input string ctx);
        logic take;
        @(negedge clk);
        check_outputs(ctx);
        take = in_valid && !flush && (!m_valid || out_ready);
        if (flush) m_valid = 0;
        else if (take) m_valid = 1;
        else if (out_ready) m_valid = 0;
        if (take) begin
            m_rs_addr = in_rs_addr; m_rt_addr = in_rt_addr; m_rd_addr = in_rd_addr;
            m_op = in_alu_op; m_funct = in_funct; m_src = in_alu_src;
            m_rs_data = in_rs_data; m_rt_data = in_rt_data; m_imm = in_imm;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] f,
                             input logic [4:0] rs_a, input logic [4:0] rt_a, input logic [4:0] rd_a,
                             input logic [31:0] rs_d, input logic [31:0] rt_d,
                             input logic [31:0] imm, input logic src);
        in_valid = 1; in_alu_op = op; in_funct = f;
        in_rs_addr = rs_a; in_rt_addr = rt_a; in_rd_addr = rd_a;
        in_rs_data = rs_d; in_rt_data = rt_d; in_imm = imm; in_alu_src = src;
    endtask

    task automatic fwd_clear();
        fwd_mem_wen = 0; fwd_mem_addr = 0; fwd_mem_data = 0;
        fwd_wb_wen = 0; fwd_wb_addr = 0; fwd_wb_data = 0;
    endtask

    logic [31:0] exp_fwd;

    initial begin
        rst_n = 0; flush = 0; out_ready = 0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 0;
        fwd_clear();
        model_reset();

        // reset state
        #12;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.alu_ctrl", ALU_Control, 4'b0010);
        chk("rst.opA", operand_A, 32'd0);
        chk("rst.opB", operand_B, 32'd0);
        chk("rst.rd", out_rd_addr, 5'd0);
        @(posedge clk); #1;
        rst_n = 1;

        // basic accept: SUB 9 - 4
        out_ready = 1;
        set_instr(2'b10, 6'b100010, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4, 32'd0, 1'b0);
        cycle("acc");
        in_valid = 0;
        chk("acc.out_valid", out_valid, 1'b1);
        chk("acc.alu_ctrl", ALU_Control, 4'b0110);
        chk("acc.opA", operand_A, 32'd9);
        chk("acc.opB", operand_B, 32'd4);
        chk("acc.rd", out_rd_addr, 5'd3);

        // stall with a waiting instruction
        out_ready = 0;
        set_instr(2'b00, 6'b000000, 5'd7, 5'd8, 5'd9, 32'h70, 32'h80, 32'h5, 1'b1);
        repeat (3) cycle("stall");
        chk("stall.in_ready", in_ready, 1'b0);
        chk("stall.opA_held", operand_A, 32'd9);
        out_ready = 1;
        cycle("stall_rel");
        in_valid = 0;
        chk("stall2.out_valid", out_valid, 1'b1);
        chk("stall2.alu_ctrl", ALU_Control, 4'b0010);
        chk("stall2.opA", operand_A, 32'h70);
        chk("stall2.opB", operand_B, 32'h5);
        cycle("drain");

        // forwarding priority on operand A
        out_ready = 0;
        set_instr(2'b10, 6'b100000, 5'd5, 5'd6, 5'd1, 32'hAA, 32'hBB, 32'd0, 1'b0);
        cycle("fwd_load");
        in_valid = 0;
        fwd_mem_wen = 1; fwd_mem_addr = 5; fwd_mem_data = 32'h11;
        fwd_wb_wen = 1;  fwd_wb_addr = 5;  fwd_wb_data = 32'h22;
        #1;
`ifdef ID_EX_FWD_EN
        exp_fwd = 32'h11;
`else
        exp_fwd = 32'hAA;
`endif
        chk("fwd.mem_over_wb", operand_A, exp_fwd);
        fwd_mem_wen = 0;
        #1;
`ifdef ID_EX_FWD_EN
        exp_fwd = 32'h22;
`else
        exp_fwd = 32'hAA;
`endif
        chk("fwd.wb_only", operand_A, exp_fwd);
        cycle("fwd_stall");
        fwd_clear();
        out_ready = 1;
        set_instr(2'b10, 6'b100000, 5'd0, 5'd0, 5'd2, 32'h33, 32'h44, 32'd0, 1'b0);
        cycle("fwd_r0_load");
        in_valid = 0; out_ready = 0;
        fwd_mem_wen = 1; fwd_mem_addr = 0; fwd_mem_data = 32'h11;
        fwd_wb_wen = 1;  fwd_wb_addr = 0;  fwd_wb_data = 32'h22;
        #1;
        chk("fwd.r0_A", operand_A, 32'h33);
        chk("fwd.r0_B", operand_B, 32'h44);
        cycle("fwd_r0");
        fwd_clear();
        out_ready = 1;
        cycle("fwd_drain");

        // flush while holding a valid entry and offering a new one
        set_instr(2'b01, 6'b0, 5'd3, 5'd4, 5'd10, 32'h123, 32'h456, 32'd0, 1'b0);
        cycle("fl_load");
        out_ready = 0; flush = 1;
        set_instr(2'b11, 6'b0, 5'd1, 5'd1, 5'd11, 32'hDEAD, 32'hBEEF, 32'd0, 1'b0);
        #1;
        chk("flush.in_ready", in_ready, 1'b0);
        cycle("flush");
        flush = 0; in_valid = 0;
        chk("flush.out_valid", out_valid, 1'b0);
        chk("flush.not_captured", operand_A, 32'h123);
        chk("flush.rd_kept", out_rd_addr, 5'd10);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_instr(2'($urandom_range(0, 3)), 6'b0,
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                      $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
            case ($urandom_range(0, 7))
                0: in_funct = 6'b100000;
                1: in_funct = 6'b100010;
                2: in_funct = 6'b100100;
                3: in_funct = 6'b100101;
                4: in_funct = 6'b101010;
                5: in_funct = 6'b100111;
                default: in_funct = 6'($urandom);
            endcase
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 9) == 0);
            fwd_mem_wen  = 1'($urandom_range(0, 1));
            fwd_mem_addr = 5'($urandom_range(0, 3));
            fwd_mem_data = $urandom;
            fwd_wb_wen   = 1'($urandom_range(0, 1));
            fwd_wb_addr  = 5'($urandom_range(0, 3));
            fwd_wb_data  = $urandom;
            cycle("rand");
        end
        flush = 0; fwd_clear();

        // asynchronous reset in the middle of a stall
        out_ready = 0;
        set_instr(2'b10, 6'b100101, 5'd2, 5'd3, 5'd4, 32'h55, 32'h66, 32'h77, 1'b0);
        cycle("ar_load");
        in_valid = 0;
        cycle("ar_stall");
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("arst.out_valid", out_valid, 1'b0);
        chk("arst.alu_ctrl", ALU_Control, 4'b0010);
        chk("arst.opA", operand_A, 32'd0);
        chk("arst.opB", operand_B, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        out_ready = 1;
        cycle("post_rst_idle");
        cycle("post_rst_idle");
        set_instr(2'b00, 6'b0, 5'd1, 5'd2, 5'd12, 32'h5, 32'h9, 32'hFFFFFFFC, 1'b1);
        cycle("imm_load");
        in_valid = 0;
        chk("imm.out_valid", out_valid, 1'b1);
        chk("imm.opB", operand_B, 32'hFFFFFFFC);
        cycle("imm_drain");
        cycle("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
